// File: rtl/level_meter_decoder.sv
// Level meter: averages |sample| over 2^AVG_LOG2 valid beats and drives an LED dot/bar display.
// Latency: 2 clk edges from the last sample of a window to led_out, with a level_valid pulse on that cycle.
// Backpressure: none; there is no tready and every valid beat is consumed.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset (led_out = all ones while in reset)
//   S_AXIS_tdata      sample, signed two's complement in bits [W-1:0], W = ADC_WIDTH-BIT_OFFSET
//   S_AXIS_tvalid     sample valid
//   mode              0 = dot, 1 = bar
//   led_out           registered LED pattern
//   level_valid       one-cycle pulse when led_out first shows a new window result
// Optional feature: define LEVEL_METER_PEAK_HOLD_EN to add the decaying peak-hold LED.
module level_meter_decoder #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BIT_OFFSET       = 0,
  parameter int LED_COUNT        = 8,
  parameter int AVG_LOG2         = 4,
  parameter int HOLD_CYCLES      = 125000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  input  logic                        mode,
  output logic [LED_COUNT-1:0]        led_out,
  output logic                        level_valid
);

  localparam int W     = ADC_WIDTH - BIT_OFFSET;
  localparam int MAG_W = W - 1;
  localparam int L     = $clog2(LED_COUNT);
  localparam int ACC_W = MAG_W + AVG_LOG2;
  // A zero-width counter is not legal; with AVG_LOG2 = 0 a 1-bit counter
  // pinned at 0 makes every valid beat the end of a window.
  localparam int                CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [W-1:0]     sample;
  logic [MAG_W-1:0] mag;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_r;
  logic [L-1:0]     idx_r;
  logic [L-1:0]     idx_new;
  logic             win_last;
  logic             win_done;
  logic             upd_r;
  logic [LED_COUNT-1:0] pattern;
  logic [LED_COUNT-1:0] led_next;

  assign sample = S_AXIS_tdata[W-1:0];

  generate
    if (AXIS_TDATA_WIDTH > W) begin : g_unused_tdata
      logic unused_tdata;
      assign unused_tdata = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:W];
    end
  endgenerate

  // |sample| in W-1 bits. Only the low bits are negated: for any negative
  // code other than the most negative one the result fits in W-1 bits, and
  // the most negative code (low bits all zero) saturates to full scale.
  always_comb begin
    mag = sample[MAG_W-1:0];
    if (sample[W-1]) begin
      if (sample[MAG_W-1:0] == '0) begin
        mag = '1;
      end else begin
        mag = ~sample[MAG_W-1:0] + MAG_W'(1);
      end
    end
  end

  // The wrapping sample is folded into the sum that produces the result, so
  // windows are back-to-back with no lost beat.
  assign acc_sum  = acc_r + ACC_W'(mag);
  assign win_last = (cnt_r == CNT_LAST);
  assign win_done = S_AXIS_tvalid && win_last;
  // Top L bits of the average: (sum >> AVG_LOG2)[W-2 -: L] is the same as
  // the top L bits of the sum itself.
  assign idx_new  = acc_sum[ACC_W-1 -: L];

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r <= '0;
      cnt_r <= '0;
      idx_r <= '0;
      upd_r <= 1'b0;
    end else begin
      upd_r <= win_done;
      if (S_AXIS_tvalid) begin
        if (win_last) begin
          cnt_r <= '0;
          acc_r <= '0;
          idx_r <= idx_new;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
          acc_r <= acc_sum;
        end
      end
    end
  end

  // Dot lights only LED idx_r; bar lights LED0 through LED idx_r.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (mode) begin
        pattern[i] = (L'(i) <= idx_r);
      end else begin
        pattern[i] = (L'(i) == idx_r);
      end
    end
  end

`ifdef LEVEL_METER_PEAK_HOLD_EN
  localparam int               HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [L-1:0]      peak_r;
  logic [HOLD_W-1:0] hold_r;

  // A new result at or above the peak captures it and restarts the hold.
  // Otherwise the hold runs down, then the peak steps toward the current
  // level one LED per hold period and stops once it meets it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      peak_r <= '0;
      hold_r <= '0;
    end else if (win_done && (idx_new >= peak_r)) begin
      peak_r <= idx_new;
      hold_r <= HOLD_RELOAD;
    end else if (hold_r != '0) begin
      hold_r <= hold_r - HOLD_W'(1);
    end else if (peak_r > idx_r) begin
      peak_r <= peak_r - L'(1);
      hold_r <= HOLD_RELOAD;
    end
  end

  assign led_next = pattern | (LED_COUNT'(1) << peak_r);
`else
  assign led_next = pattern;
`endif

  // Reset holds every LED on as a lamp test.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_out     <= '1;
      level_valid <= 1'b0;
    end else begin
      led_out     <= led_next;
      level_valid <= upd_r;
    end
  end

endmodule

// File: doc/level_meter_decoder.md
LEVEL_METER_DECODER -- requirements
Module: level_meter_decoder

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 14, ADC sample width in bits.
REQ-002 SHALL have parameter AXIS_TDATA_WIDTH, default 32, stream data width.
REQ-003 SHALL have parameter BIT_OFFSET, default 0, range-setting offset: 4 for +/-20 V, 0 for +/-1 V; effective width W = ADC_WIDTH-BIT_OFFSET.
REQ-004 SHALL have parameter LED_COUNT, default 8, LED outputs; power of two, 2..16; L = log2(LED_COUNT).
REQ-005 SHALL have parameter AVG_LOG2, default 4, averaging window of 2^AVG_LOG2 valid samples; range 0..8.
REQ-006 SHALL have parameter HOLD_CYCLES, default 125000000, peak-hold time in clk cycles; minimum 1.
REQ-007 SHALL have port clk  input  1  clock, 125 MHz.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port S_AXIS_tdata  input  AXIS_TDATA_WIDTH  sample; signed two's-complement value in bits [W-1:0].
REQ-010 SHALL have port S_AXIS_tvalid  input  1  sample valid; no tready, every valid beat is consumed.
REQ-011 SHALL have port mode  input  1  display mode: 0 = dot, 1 = bar.
REQ-012 SHALL have port led_out  output  LED_COUNT  registered LED pattern.
REQ-013 SHALL have port level_valid  output  1  one-cycle pulse on each new window result.

Function
REQ-014 Magnitude SHALL be |sample|, W-1 bits; the most negative code SHALL saturate to 2^(W-1)-1.
REQ-015 On each cycle with tvalid=1, the magnitude SHALL be added to an accumulator of W-1+AVG_LOG2 bits, and the sample counter (AVG_LOG2 bits) SHALL increment modulo 2^AVG_LOG2; with tvalid=0, accumulator and counter SHALL hold.
REQ-016 On the edge accepting the last sample of a window (counter wraps), idx_r SHALL load bits [W-2 -: L] of (accumulator+magnitude)>>AVG_LOG2, and the accumulator SHALL clear; the wrapping sample belongs to the completed window.
REQ-017 led_out SHALL be re-registered every cycle from idx_r, peak_r and mode; latency from the last window sample to led_out is 2 clk edges.
REQ-018 Dot mode SHALL light bit idx_r only; bar mode SHALL light bits 0..idx_r inclusive; idx_r=0 lights LED0.
REQ-019 mode changes SHALL appear on led_out on the next edge, independent of window timing.
REQ-020 level_valid SHALL be high for exactly the cycle in which led_out first reflects a new idx_r, including an unchanged value.
REQ-021 Windows SHALL be back-to-back, with no dropped sample at window boundaries.

Reset
REQ-022 While rst=0, led_out SHALL be all ones (lamp test); level_valid, accumulator, counter, idx_r, peak_r and the hold counter SHALL be zero.
REQ-023 Reset mid-window SHALL discard partial accumulation; the first window after release starts with the first valid sample.
REQ-024 On the first edge after release, led_out SHALL show idx 0 (LED0, plus the peak bit at 0).

Configuration
REQ-025 Macro LEVEL_METER_PEAK_HOLD_EN, when defined, SHALL compile in the peak-hold tracker (peak_r, L bits; hold counter sized for HOLD_CYCLES).
REQ-026 With the macro defined: on each idx_r update with new idx >= peak_r, peak_r SHALL load idx and the hold counter SHALL load HOLD_CYCLES-1.
REQ-027 Otherwise, a nonzero hold counter SHALL decrement each cycle; at zero with peak_r > idx_r, peak_r SHALL decrement by 1 and the counter SHALL reload HOLD_CYCLES-1; at zero with peak_r = idx_r, both SHALL hold.
REQ-028 In both modes, bit peak_r SHALL be ORed into led_out.
REQ-029 Without the macro, there SHALL be no peak logic and led_out SHALL depend on idx_r and mode only.

Verification (W=14, AVG_LOG2=2, LED_COUNT=8, HOLD_CYCLES=4, macro defined unless noted)
REQ-030 Four valid samples of 3072 with mode=1 -> led_out=0x0F; with mode=0 -> 0x08; level_valid pulses once, 2 edges after the 4th sample.
REQ-031 Four samples of -3072 (0x3400) -> idx 3, same output as 3072; four samples of -8192 (0x2000) -> saturates, idx 7, bar 0xFF.
REQ-032 Samples 4096,0,0,0 with tvalid gaps of 3 cycles between beats -> idx 1, bar 0x03; no level_valid before the 4th valid beat.
REQ-033 A window at idx 7, then continuous windows at idx 0, dot mode -> 0x81 held for 4 cycles; peak then steps down by 1 every 4 cycles until 0x01.
REQ-034 rst=0 after 2 samples of 8191 -> led_out=0xFF during reset; after release, four samples of 1024 -> idx 1; built without the macro, scenario REQ-033 gives 0x01 immediately.
